regfile_sb: RTL

- 32x32 register file with an integrated per-register pending-write scoreboard.
- It is the consumer of the write-back port: it takes the write address, write data and write enable driven by the write-back stage and commits them.
- Decode reads two operands from it combinationally, with a same-cycle bypass from the write port.
- Decode uses the busy flags to stall on RAW hazards until the producing instruction has written back.

---
 rtl/regfile_sb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 32x32 register file with a per-register pending-write scoreboard.
// Two combinational read ports with write-through bypass, one write-back port,
// and saturating in-flight write counters that drive RAW busy flags for decode.
// The last register index is hardwired to zero and is never tracked.
module regfile_sb #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [4:0]        ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              WERF,
    input  logic              issue_en,
    input  logic [4:0]        issue_wa,
    input  logic              flush,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_err
);

    localparam logic [4:0]       ZERO_REG = 5'(NREGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q  [NREGS];
    logic [CNT_W-1:0]  cnt_d  [NREGS];
    logic              sb_err_q;
    logic              sb_err_d;

    logic inc;
    logic dec;
    logic same_reg;

    // A write to the zero register neither commits nor retires a pending write.
    assign inc      = issue_en && (issue_wa != ZERO_REG);
    assign dec      = WERF && (wa != ZERO_REG);
    assign same_reg = inc && dec && (issue_wa == wa);

    // Next storage contents: commit the write-back data when enabled.
    always_comb begin
        regs_d = regs_q;
        if (dec) begin
            regs_d[wa] = wd;
        end
    end

    // Next scoreboard state: flush clears everything, otherwise saturating inc/dec.
    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (flush) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_d[r] = '0;
            end
        end else begin
            if (inc && !same_reg) begin
                if (cnt_q[issue_wa] == CNT_MAX) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[issue_wa] = cnt_q[issue_wa] + CNT_ONE;
                end
            end
            if (dec && !same_reg) begin
                if (cnt_q[wa] != '0) begin
                    cnt_d[wa] = cnt_q[wa] - CNT_ONE;
                end
            end
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Read port 1: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        rd1 = '0;
        if (n_rst && (ra1 != ZERO_REG)) begin
            if (dec && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = regs_q[ra1];
            end
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2 = '0;
        if (n_rst && (ra2 != ZERO_REG)) begin
            if (dec && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = regs_q[ra2];
            end
        end
    end

    // Busy for port 1: pending writes, cleared early by the last write-back landing now.
    always_comb begin
        busy1 = 1'b0;
        if (n_rst && (ra1 != ZERO_REG)) begin
            busy1 = (cnt_q[ra1] != '0) &&
                    !(dec && (wa == ra1) && (cnt_q[ra1] == CNT_ONE));
        end
    end

    // Busy for port 2: same rule as port 1.
    always_comb begin
        busy2 = 1'b0;
        if (n_rst && (ra2 != ZERO_REG)) begin
            busy2 = (cnt_q[ra2] != '0) &&
                    !(dec && (wa == ra2) && (cnt_q[ra2] == CNT_ONE));
        end
    end

    assign sb_err = sb_err_q;

endmodule
